// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the MIPS execute stage.
// Owns the architectural HI/LO registers.
//   MULT/MULTU : shift-add, one multiplier bit per cycle, LSB first.
//   DIV/DIVU   : restoring divide, one quotient bit per cycle, MSB first.
//   MTHI/MTLO  : single-cycle write of `a` into HI/LO at the accept edge.
// Latency: accept edge E0, 32 CALC edges (E1..E32), FIX edge E33 writes HI/LO.
// `done` is high for the cycle after E33.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present this cycle
//   req_ready  out  unit can accept a request (IDLE && !flush)
//   op         in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a          in   rs operand / dividend / MTHI-MTLO data
//   b          in   rt operand / divisor
//   flush      in   abort the operation in flight; HI/LO untouched
//   busy       out  multi-cycle operation in progress
//   done       out  one-cycle pulse after HI/LO written by a mult/div
//   hi, lo     out  HI/LO registers
//   dbg_state  out  current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; req_valid is not required to stay high afterwards,
// and nothing is accepted while req_ready is low (busy or flush).

module mdu_iter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2*WIDTH-1:0] r_acc;    // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opb;    // mult: multiplicand magnitude; div: divisor magnitude
    logic [WIDTH-1:0]   r_araw;   // raw dividend, returned in HI on divide by zero
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_div0;
    logic               r_neg_q;  // product / quotient sign
    logic               r_neg_r;  // remainder sign
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_is_muldiv;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_shifted;
    logic               w_ge;
    logic [WIDTH-1:0]   w_newrem;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign req_ready   = (r_state == IDLE) && !flush;
    assign w_accept    = req_valid && req_ready;
    assign w_is_muldiv = (op[2] == 1'b0);
    // ops 0 (MULT) and 2 (DIV) are the signed ones
    assign w_signed    = w_is_muldiv && (op[0] == 1'b0);
    assign w_sa        = w_signed && a[WIDTH-1];
    assign w_sb        = w_signed && b[WIDTH-1];
    assign w_mag_a     = w_sa ? -a : a;
    assign w_mag_b     = w_sb ? -b : b;

    // Multiply step: conditionally add multiplicand into the upper half, shift right.
    assign w_msum = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb})
                             : {1'b0, r_acc[2*WIDTH-1:WIDTH]};

    // Divide step: shift next dividend bit into the 33-bit partial remainder and
    // subtract when it fits. When it does not fit, bit WIDTH is known to be 0.
    assign w_shifted = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_shifted >= {1'b0, r_opb});
    assign w_newrem  = w_ge ? (w_shifted[WIDTH-1:0] - r_opb) : w_shifted[WIDTH-1:0];

    assign w_step = r_is_div ? {w_newrem, r_acc[WIDTH-2:0], w_ge}
                             : {w_msum, r_acc[WIDTH-1:1]};

    // Sign correction applied at FIX.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_muldiv) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_araw   <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            // flush on the FIX edge suppresses both the write and the pulse
            r_done <= (r_state == FIX) && !flush;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op)
                            3'd4: r_hi <= a;
                            3'd5: r_lo <= a;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_is_div <= op[1];
                                r_div0   <= op[1] && (b == '0);
                                r_araw   <= a;
                                r_neg_q  <= w_sa ^ w_sb;
                                r_neg_r  <= w_sa;
                                r_cnt    <= '0;
                                if (op[1]) begin
                                    r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                                    r_opb <= w_mag_b;
                                end else begin
                                    r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                                    r_opb <= w_mag_a;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (!r_is_div) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_div0) begin
                            r_hi <= r_araw;
                            r_lo <= DIV0_LO;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter with hand-computed expected values.
module tb_mdu_iter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mdu_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge; returns #1 after that edge.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        req_valid = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op        = 3'd6;
    endtask

    // Run a mult/div and check latency, done pulse and HI/LO.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        send(o, x, y);
        check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        check({tag, "_rdy0"}, {31'd0, req_ready}, 32'd0);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, 32'd33);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        @(posedge clk);
        #1;
        check({tag, "_done1"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        op        = 3'd6;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rdy", {31'd0, req_ready}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        // multiply
        run_md("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("mult_m1m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

        // divide
        run_md("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);
        run_md("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("divu_by0", 3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_md("div_by0_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // MTHI / MTLO: single cycle, no busy, no done
        send(3'd4, 32'h11, 32'd0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);
        send(3'd5, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);
        check("mtlo_hi", hi, 32'h11);
        check("mtlo_done", {31'd0, done}, 32'd0);

        // no-op
        send(3'd7, 32'hDEAD, 32'hBEEF);
        check("nop_hi", hi, 32'h11);
        check("nop_lo", lo, 32'h22);
        check("nop_busy", {31'd0, busy}, 32'd0);

        // flush mid-CALC
        send(3'd2, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("fl_busy_pre", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_busy", {31'd0, busy}, 32'd0);
        check("fl_done", {31'd0, done}, 32'd0);
        check("fl_hi", hi, 32'h11);
        check("fl_lo", lo, 32'h22);
        n = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) n++;
        end
        check("fl_quiet", n, 32'd0);

        // flush in IDLE blocks even MTHI
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        op        = 3'd4;
        a         = 32'h99;
        #1;
        check("fl_idle_rdy", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fl_idle_hi", hi, 32'h11);

        // MTHI held during busy is accepted only once ready
        send(3'd0, 32'd3, 32'd5);
        req_valid = 1'b1;
        op        = 3'd4;
        a         = 32'h55;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) begin
                check("hold_rdy", {31'd0, req_ready}, 32'd0);
            end
        end
        check("hold_lat", n, 32'd33);
        check("hold_hi_mult", hi, 32'd0);
        check("hold_lo_mult", lo, 32'd15);
        check("hold_rdy_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op        = 3'd6;
        check("hold_hi", hi, 32'h55);
        check("hold_lo", lo, 32'd15);
        check("hold_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-operation
        send(3'd0, 32'hFFFF_FFFD, 32'd7);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        #3;
        rst_n = 1'b1;
        #1;
        check("arst_rdy", {31'd0, req_ready}, 32'd1);
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy || hi != 32'd0 || lo != 32'd0) n++;
        end
        check("arst_quiet", n, 32'd0);

        // unit still works after reset
        run_md("post_rst", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
